// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a valid/ready request/response handshake.
// Define DMEM_BYTE_STROBE_EN to add the req_be byte-enable port for partial writes.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  req_be,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  logic          cap_write;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_wdata;
  logic [3:0]    cap_be;
  logic [3:0]    be_in;

  logic          acc_write;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_be;
  logic          acc_err;
  logic [IW-1:0] acc_idx;
  logic [31:0]   acc_word;
  logic [31:0]   acc_rdata;
  logic [31:0]   merged;

  logic          accept;
  logic          do_access;
  logic          mem_we;

  logic [31:0]   mem [DEPTH];

`ifdef DMEM_BYTE_STROBE_EN
  assign be_in = req_be;
`else
  assign be_in = 4'hF;
`endif

  assign accept    = (state == IDLE) && req_valid;
  assign do_access = (WAIT_CYCLES == 0) ? accept : ((state == WAIT) && (wait_cnt == '0));

  // With no wait states the access happens on the acceptance edge, so use live inputs
  assign acc_write = (state == IDLE) ? req_write : cap_write;
  assign acc_addr  = (state == IDLE) ? req_addr  : cap_addr;
  assign acc_wdata = (state == IDLE) ? req_wdata : cap_wdata;
  assign acc_be    = (state == IDLE) ? be_in     : cap_be;

  always_comb begin
    acc_idx  = acc_addr[IW+1:2];
    acc_err  = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
    acc_word = acc_err ? 32'h0 : mem[acc_idx];
    merged   = acc_word;
    for (int i = 0; i < 4; i++) begin
      if (acc_be[i]) merged[8*i +: 8] = acc_wdata[8*i +: 8];
    end
    acc_rdata = (acc_write || acc_err) ? 32'h0 : acc_word;
  end

  assign mem_we = do_access && acc_write && !acc_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[acc_idx] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      cap_write <= 1'b0;
      cap_addr  <= 32'h0;
      cap_wdata <= 32'h0;
      cap_be    <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= be_in;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= acc_rdata;
              rsp_err   <= acc_err;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= acc_rdata;
            rsp_err   <= acc_err;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          // req_ready returns only after the handshake edge, so no same-cycle reissue
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a 2-wait-state instance driven from a vector table,
// plus a zero-wait instance for back-to-back traffic, and a mid-transaction reset.
module tb_data_mem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid2, req_valid0;
  logic        req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_ready;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  req_be;
`endif

  logic        req_ready2, rsp_valid2, rsp_err2;
  logic [31:0] rsp_rdata2;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  logic        sel0;
  logic        cur_req_ready, cur_rsp_valid, cur_rsp_err;
  logic [31:0] cur_rsp_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be(req_be),
`endif
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2)
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be(req_be),
`endif
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  assign cur_req_ready = sel0 ? req_ready0 : req_ready2;
  assign cur_rsp_valid = sel0 ? rsp_valid0 : rsp_valid2;
  assign cur_rsp_err   = sel0 ? rsp_err0   : rsp_err2;
  assign cur_rsp_rdata = sel0 ? rsp_rdata0 : rsp_rdata2;

  function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] be,
                              int hold, logic [31:0] rd, bit e);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.be = be;
    v.hold = hold; v.rdata = rd; v.err = e;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction on the selected instance, checking latency, data and handshake
  task automatic applyStimulus(input vec_t v, input string tag);
    int n;
    int lat;
    int exp_lat;
    exp_lat = sel0 ? 1 : 3;
    @(negedge clk);
    n = 0;
    while (!cur_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cur_req_ready) begin
      checkOutput({tag, " ready timeout"}, 32'(cur_req_ready), 32'd1);
      return;
    end
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
`ifdef DMEM_BYTE_STROBE_EN
    req_be    = v.be;
`endif
    if (sel0) req_valid0 = 1'b1;
    else      req_valid2 = 1'b1;
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    req_valid2 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cur_rsp_valid && lat < 20);
    checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, " rdata"}, cur_rsp_rdata, v.rdata);
    checkOutput({tag, " err"}, 32'(cur_rsp_err), 32'(v.err));
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      checkOutput({tag, " stall valid"}, 32'(cur_rsp_valid), 32'd1);
      checkOutput({tag, " stall rdata"}, cur_rsp_rdata, v.rdata);
      checkOutput({tag, " stall ready"}, 32'(cur_req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput({tag, " post valid"}, 32'(cur_rsp_valid), 32'd0);
    checkOutput({tag, " post rdata"}, cur_rsp_rdata, 32'h0);
    checkOutput({tag, " post err"}, 32'(cur_rsp_err), 32'd0);
    checkOutput({tag, " post ready"}, 32'(cur_req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accepted;
    int resps;
    rst = 1'b0;
    req_valid2 = 1'b0;
    req_valid0 = 1'b0;
    req_write = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b0;
    sel0 = 1'b0;
`ifdef DMEM_BYTE_STROBE_EN
    req_be = 4'hF;
`endif

    vecs.push_back(mk(1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 32'h0,        0));
    vecs.push_back(mk(0, 32'h10,  32'h0,        4'hF, 5, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 32'h12,  32'h0,        4'hF, 0, 32'h0,        1));
    vecs.push_back(mk(0, 32'h400, 32'h0,        4'hF, 0, 32'h0,        1));
    vecs.push_back(mk(1, 32'h0,   32'h11111111, 4'hF, 0, 32'h0,        0));
    vecs.push_back(mk(1, 32'h12,  32'hAAAAAAAA, 4'hF, 0, 32'h0,        1));
    vecs.push_back(mk(1, 32'h400, 32'hBBBBBBBB, 4'hF, 0, 32'h0,        1));
    vecs.push_back(mk(0, 32'h10,  32'h0,        4'hF, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 32'h0,   32'h0,        4'hF, 0, 32'h11111111, 0));
    vecs.push_back(mk(1, 32'h3FC, 32'hCAFEF00D, 4'hF, 0, 32'h0,        0));
    vecs.push_back(mk(0, 32'h3FC, 32'h0,        4'hF, 0, 32'hCAFEF00D, 0));
    vecs.push_back(mk(0, 32'h3FD, 32'h0,        4'hF, 0, 32'h0,        1));
    vecs.push_back(mk(1, 32'h10,  32'h01234567, 4'hF, 0, 32'h0,        0));
    vecs.push_back(mk(0, 32'h10,  32'h0,        4'hF, 0, 32'h01234567, 0));
    vecs.push_back(mk(0, 32'h8,   32'h0,        4'hF, 0, 32'h0,        0));
    vecs.push_back(mk(1, 32'h8,   32'hFFFFFFFF, 4'hF, 0, 32'h0,        0));
    vecs.push_back(mk(1, 32'h8,   32'h00000000, 4'b0101, 0, 32'h0,     0));
`ifdef DMEM_BYTE_STROBE_EN
    vecs.push_back(mk(0, 32'h8,   32'h0,        4'hF, 0, 32'hFF00FF00, 0));
`else
    vecs.push_back(mk(0, 32'h8,   32'h0,        4'hF, 0, 32'h00000000, 0));
`endif

    repeat (3) @(negedge clk);
    checkOutput("reset valid", 32'(rsp_valid2), 32'd0);
    checkOutput("reset rdata", rsp_rdata2, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("release ready", 32'(req_ready2), 32'd1);
    checkOutput("release valid", 32'(rsp_valid2), 32'd0);
    checkOutput("release err", 32'(rsp_err2), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("v%0d", i));
    end

    // Zero-wait instance: preload a word, then hold req_valid and rsp_ready high
    sel0 = 1'b1;
    applyStimulus(mk(1, 32'h4, 32'h12345678, 4'hF, 0, 32'h0, 0), "z write");
    applyStimulus(mk(0, 32'h4, 32'h0, 4'hF, 2, 32'h12345678, 0), "z read");
    @(negedge clk);
    req_write  = 1'b0;
    req_addr   = 32'h4;
    req_valid0 = 1'b1;
    rsp_ready  = 1'b1;
    accepted = 0;
    resps = 0;
    for (int i = 0; i < 8; i++) begin
      if (req_ready0) accepted++;
      @(negedge clk);
      checkOutput($sformatf("b2b valid %0d", i), 32'(rsp_valid0), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (rsp_valid0) begin
        resps++;
        checkOutput($sformatf("b2b rdata %0d", i), rsp_rdata0, 32'h12345678);
      end
    end
    req_valid0 = 1'b0;
    rsp_ready  = 1'b0;
    checkOutput("b2b accepted", 32'(accepted), 32'd4);
    checkOutput("b2b responses", 32'(resps), 32'd4);

    // Reset while a write sits in WAIT: nothing committed, whole memory cleared
    sel0 = 1'b0;
    @(negedge clk);
    req_write  = 1'b1;
    req_addr   = 32'h20;
    req_wdata  = 32'h55;
    req_valid2 = 1'b1;
    @(posedge clk);
    #1;
    req_valid2 = 1'b0;
    checkOutput("wait ready", 32'(req_ready2), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("midrst valid", 32'(rsp_valid2), 32'd0);
    checkOutput("midrst rdata", rsp_rdata2, 32'h0);
    checkOutput("midrst err", 32'(rsp_err2), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(mk(0, 32'h20, 32'h0, 4'hF, 0, 32'h0, 0), "rst read20");
    applyStimulus(mk(0, 32'h10, 32'h0, 4'hF, 0, 32'h0, 0), "rst read10");
    sel0 = 1'b1;
    applyStimulus(mk(0, 32'h4, 32'h0, 4'hF, 0, 32'h0, 0), "rst read4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
